seg7_capture: RTL and testbench

Reverse of the nibble-to-segment encoder: watches a multiplexed 7-segment display bus (segment lines plus one-hot digit selects) and recovers the hex value shown. Each digit's segment pattern is qualified for stability, decoded back to a nibble, and assembled into a multi-digit frame. Each frame is delivered on a valid/ready interface. It sits between the display-driver pins and any logic that must check or log what is shown: self-test, loopback, or sniffing an external display.

---
 rtl/seg7_capture.sv | 186 ++++++++++++++++++
 tb/tb_seg7_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// seg7_capture
//
// Watches a multiplexed 7-segment display bus and recovers the hex value on
// it. The block registers the bus once and qualifies each digit for
// stability. It then decodes the segment pattern back to a nibble and builds
// a multi-digit frame. Each frame is handed out on a valid/ready interface.
//
// Ports
//   i_clk        : single clock
//   i_reset      : synchronous, active-high reset
//   i_segments   : segment lines, bit0 = a ... bit6 = g, active high
//   i_digit_sel  : one-hot digit selects, bit k = digit k (LS nibble = digit 0)
//   o_value      : decoded frame, nibble k from digit k
//   o_digit_err  : bit k set when digit k showed an illegal pattern
//   o_valid      : frame available
//   i_ready      : consumer accepts the frame
//   o_overrun    : sticky, set when a completed frame had to be dropped
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [6:0]            i_segments,
  input  logic [DIGITS-1:0]     i_digit_sel,
  output logic [4*DIGITS-1:0]   o_value,
  output logic [DIGITS-1:0]     o_digit_err,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overrun
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_WAIT,
    S_COUNT,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [6:0]            seg_q;
  logic [DIGITS-1:0]     sel_q;
  logic [7:0]            cnt_q, cnt_d;
  logic                  in_onehot;
  logic                  in_changed;
  logic                  capture;
  logic [4:0]            dec;
  logic [4*DIGITS-1:0]   slot_val, frame_val;
  logic [DIGITS-1:0]     slot_err, frame_err;
  logic [DIGITS-1:0]     mask_q, mask_next;
  logic                  frame_done;
  logic                  out_free;

  // Segment pattern to {illegal, nibble}. An illegal pattern returns nibble 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h67:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // The counter and the sample register load on the same edge. The count
  // therefore always describes the sample currently held: it is 1 in the
  // first cycle a new pair sits in the register. This is what makes capture
  // land exactly STABLE_CYCLES cycles after the pair is applied.
  always_comb begin
    in_onehot  = $onehot(i_digit_sel);
    in_changed = (i_segments != seg_q) || (i_digit_sel != sel_q);
    if (!in_onehot)
      cnt_d = 8'd0;
    else if (in_changed)
      cnt_d = 8'd1;
    else if (cnt_q >= STABLE_MAX)
      cnt_d = STABLE_MAX;
    else
      cnt_d = cnt_q + 8'd1;
  end

  // Digit FSM. CAPTURE and HOLD both react to a change in the incoming pair.
  // A digit dwelling exactly STABLE_CYCLES is replaced right after its
  // capture cycle, and that change must not be missed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (in_onehot)
          state_d = S_COUNT;
      end
      S_COUNT: begin
        if (!in_onehot)
          state_d = S_WAIT;
        else if (cnt_d == STABLE_MAX)
          state_d = S_CAPTURE;
        else
          state_d = S_COUNT;
      end
      S_CAPTURE, S_HOLD: begin
        if (in_changed)
          state_d = in_onehot ? S_COUNT : S_WAIT;
        else
          state_d = S_HOLD;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Merge the digit being captured into the frame slots. The completing
  // capture is included in the frame that is handed out.
  always_comb begin
    capture   = (state_q == S_CAPTURE);
    dec       = decode_seg(seg_q);
    frame_val = slot_val;
    frame_err = slot_err;
    for (int k = 0; k < DIGITS; k++) begin
      if (capture && sel_q[k]) begin
        frame_val[4*k +: 4] = dec[3:0];
        frame_err[k]        = dec[4];
      end
    end
    mask_next  = capture ? (mask_q | sel_q) : mask_q;
    frame_done = capture && (&mask_next);
    out_free   = !o_valid || i_ready;
  end

  // Sample register, stability counter, FSM state and frame slots.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      seg_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      state_q  <= S_WAIT;
      slot_val <= '0;
      slot_err <= '0;
      mask_q   <= '0;
    end else begin
      seg_q    <= i_segments;
      sel_q    <= i_digit_sel;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      slot_val <= frame_val;
      slot_err <= frame_err;
      mask_q   <= frame_done ? '0 : mask_next;
    end
  end

  // Output register. A finished frame loads only when the register is free.
  // Otherwise it is dropped and flagged; the held frame is left untouched.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_value     <= '0;
      o_digit_err <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
    end else if (frame_done) begin
      if (out_free) begin
        o_value     <= frame_val;
        o_digit_err <= frame_err;
        o_valid     <= 1'b1;
      end else begin
        o_overrun   <= 1'b1;
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture
//
// Scoreboard bench for seg7_capture. Directed frames are shown on the
// display bus, and each frame's expected value/error word is queued as it is
// issued. A monitor pops the queue whenever the DUT hands out a frame. Any
// frame arriving with nothing queued counts as an error.
module tb_seg7_capture;

  localparam int DIGITS = 4;
  localparam int S      = 4;

  logic                clk = 1'b0;
  logic                i_reset;
  logic [6:0]          i_segments;
  logic [DIGITS-1:0]   i_digit_sel;
  logic [4*DIGITS-1:0] o_value;
  logic [DIGITS-1:0]   o_digit_err;
  logic                o_valid;
  logic                i_ready;
  logic                o_overrun;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_item;

  seg7_capture #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (S)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_segments  (i_segments),
    .i_digit_sel (i_digit_sel),
    .o_value     (o_value),
    .o_digit_err (o_digit_err),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  // Direct comparison of an output against a bench constant.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one (select, segments) pair for 'dwell' sampling edges. The task
  // returns just after the last edge, so the next pair starts there.
  task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] seg,
                               input int dwell);
    i_digit_sel = sel;
    i_segments  = seg;
    repeat (dwell) @(posedge clk);
    #1;
  endtask

  task automatic expectFrame(input logic [15:0] value, input logic [3:0] err);
    exp_q.push_back({err, value});
  endtask

  // Scoreboard monitor: a frame transfers on the edge after this negedge.
  always @(negedge clk) begin
    if (!i_reset && o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_frame: got value 0x%h err %b, expected no frame",
                 o_value, o_digit_err);
      end else begin
        exp_item = exp_q.pop_front();
        if ({o_digit_err, o_value} !== exp_item) begin
          errors++;
          $display("[TB] FAIL frame: got value 0x%h err %b, expected value 0x%h err %b",
                   o_value, o_digit_err, exp_item[15:0], exp_item[19:16]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset     = 1'b1;
    i_segments  = '0;
    i_digit_sel = '0;
    i_ready     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_value",   o_value,            16'h0000);
    checkOutput("reset_err",     16'(o_digit_err),   16'h0000);
    checkOutput("reset_valid",   16'(o_valid),       16'h0000);
    checkOutput("reset_overrun", 16'(o_overrun),     16'h0000);
    @(posedge clk);
    #1 i_reset = 1'b0;
    applyStimulus(4'b0000, 7'h00, 3);

    // Basic frame 0x3210 with a latency check on the completing digit.
    $display("[TB] frame 0x3210");
    expectFrame(16'h3210, 4'b0000);
    applyStimulus(4'b0001, 7'h3F, 6);
    applyStimulus(4'b0010, 7'h06, 6);
    applyStimulus(4'b0100, 7'h5B, 6);
    i_digit_sel = 4'b1000;
    i_segments  = 7'h4F;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("valid_before_latency", 16'(o_valid), 16'h0000);
    @(posedge clk);
    @(negedge clk);
    checkOutput("valid_at_latency", 16'(o_valid), 16'h0001);
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 7'h00, 8);

    // Minimum dwell captures; one cycle shorter never does.
    $display("[TB] frame 0xBEEF then short dwell");
    expectFrame(16'hBEEF, 4'b0000);
    applyStimulus(4'b0001, 7'h71, S);
    applyStimulus(4'b0010, 7'h79, S);
    applyStimulus(4'b0100, 7'h79, S);
    applyStimulus(4'b1000, 7'h7C, S);
    applyStimulus(4'b0000, 7'h00, 8);
    applyStimulus(4'b0001, 7'h06, S-1);
    applyStimulus(4'b0010, 7'h5B, S-1);
    applyStimulus(4'b0100, 7'h4F, S-1);
    applyStimulus(4'b1000, 7'h66, S-1);
    applyStimulus(4'b0000, 7'h00, 20);
    checkOutput("short_dwell_no_valid", 16'(o_valid), 16'h0000);
    checkOutput("short_dwell_value_held", o_value, 16'hBEEF);

    // Illegal pattern on digit 2.
    $display("[TB] illegal digit");
    expectFrame(16'h8088, 4'b0100);
    applyStimulus(4'b0001, 7'h7F, 6);
    applyStimulus(4'b0010, 7'h7F, 6);
    applyStimulus(4'b0100, 7'h49, 6);
    applyStimulus(4'b1000, 7'h7F, 6);
    applyStimulus(4'b0000, 7'h00, 8);

    // Glitching digit 0 and a multi-hot select must never capture.
    $display("[TB] glitch and multi-hot");
    applyStimulus(4'b0001, 7'h3F, 2);
    applyStimulus(4'b0001, 7'h06, 3);
    applyStimulus(4'b0001, 7'h3F, 1);
    applyStimulus(4'b0001, 7'h5B, 3);
    applyStimulus(4'b0011, 7'h3F, 10);
    applyStimulus(4'b0010, 7'h5B, 6);
    applyStimulus(4'b0100, 7'h4F, 6);
    applyStimulus(4'b1000, 7'h66, 6);
    applyStimulus(4'b0000, 7'h00, 10);
    checkOutput("glitch_value_held", o_value, 16'h8088);
    expectFrame(16'h4325, 4'b0000);
    applyStimulus(4'b0001, 7'h6D, 6);
    applyStimulus(4'b0000, 7'h00, 8);

    // Overwrite of a re-shown digit, and a long-held digit captured once.
    $display("[TB] overwrite and long hold");
    expectFrame(16'h3240, 4'b0000);
    applyStimulus(4'b0010, 7'h06, 6);
    applyStimulus(4'b0100, 7'h5B, 6);
    applyStimulus(4'b1000, 7'h4F, 6);
    applyStimulus(4'b0010, 7'h66, 6);
    applyStimulus(4'b0001, 7'h3F, 50);
    applyStimulus(4'b0010, 7'h07, 6);
    applyStimulus(4'b0100, 7'h7F, 6);
    applyStimulus(4'b1000, 7'h67, 6);
    applyStimulus(4'b0000, 7'h00, 20);
    checkOutput("held_digit_once", o_value, 16'h3240);
    expectFrame(16'h987A, 4'b0000);
    applyStimulus(4'b0001, 7'h77, 6);
    applyStimulus(4'b0000, 7'h00, 8);

    // Back-pressure: the second frame is dropped and flagged.
    $display("[TB] overrun");
    i_ready = 1'b0;
    expectFrame(16'h1234, 4'b0000);
    applyStimulus(4'b0001, 7'h66, 6);
    applyStimulus(4'b0010, 7'h4F, 6);
    applyStimulus(4'b0100, 7'h5B, 6);
    applyStimulus(4'b1000, 7'h06, 6);
    applyStimulus(4'b0001, 7'h7F, 6);
    applyStimulus(4'b0010, 7'h07, 6);
    applyStimulus(4'b0100, 7'h7D, 6);
    applyStimulus(4'b1000, 7'h6D, 6);
    applyStimulus(4'b0000, 7'h00, 5);
    checkOutput("overrun_set",        16'(o_overrun), 16'h0001);
    checkOutput("overrun_valid_held", 16'(o_valid),   16'h0001);
    checkOutput("overrun_value_held", o_value,        16'h1234);
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
    @(negedge clk);
    checkOutput("valid_drop_after_ready", 16'(o_valid), 16'h0000);
    @(posedge clk);
    #1 i_ready = 1'b1;

    // Reset in the middle of a frame discards the partial frame.
    $display("[TB] mid-frame reset");
    applyStimulus(4'b0001, 7'h7F, 6);
    applyStimulus(4'b0010, 7'h7F, 6);
    applyStimulus(4'b0100, 7'h7F, 6);
    i_reset     = 1'b1;
    i_digit_sel = '0;
    i_segments  = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("inreset_value",   o_value,          16'h0000);
    checkOutput("inreset_err",     16'(o_digit_err), 16'h0000);
    checkOutput("inreset_valid",   16'(o_valid),     16'h0000);
    checkOutput("inreset_overrun", 16'(o_overrun),   16'h0000);
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("postreset_value",   o_value,        16'h0000);
    checkOutput("postreset_valid",   16'(o_valid),   16'h0000);
    checkOutput("postreset_overrun", 16'(o_overrun), 16'h0000);
    @(posedge clk);
    #1;
    expectFrame(16'hA5C3, 4'b0000);
    applyStimulus(4'b1000, 7'h77, 6);
    applyStimulus(4'b0001, 7'h4F, 6);
    applyStimulus(4'b0010, 7'h39, 6);
    applyStimulus(4'b0100, 7'h6D, 6);
    applyStimulus(4'b0000, 7'h00, 10);

    checkOutput("pending_frames", 16'(exp_q.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
